uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//  Run-time configurable UART transmitter with a ready/valid byte input.
//  Serialises one frame per accepted word: start bit, 1..NB_DATA data bits (LSB first),
//  optional even/odd parity and 1 or 2 stop bits. Each bit lasts OVERSAMPLE baud ticks.
//  Sits between a TX FIFO/host interface and the pad. Takes i_tick from the shared baud generator.
// PARAMETERS
//  NB_DATA     8   max data bits per frame (width of i_data)
//  OVERSAMPLE  16  i_tick pulses per serial bit (>=2)
//  NB_NBITS    4   width of i_cfg_nbits (>= clog2(NB_DATA+1))
// PORTS
//  i_clock          in   1         system clock
//  i_reset          in   1         synchronous, active-high reset
//  i_tick           in   1         baud tick enable, 1-cycle pulse
//  i_data           in   NB_DATA   word to send, LSB first
//  i_data_valid     in   1         i_data is valid
//  o_data_ready     out  1         block can accept a word this cycle
//  i_cfg_nbits      in   NB_NBITS  data bits per frame (1..NB_DATA)
//  i_cfg_parity_en  in   1         1 = append parity bit
//  i_cfg_parity_odd in   1         1 = odd parity, 0 = even parity
//  i_cfg_stop2      in   1         1 = two stop bits, 0 = one stop bit
//  o_tx             out  1         serial line, idle high, registered
//  o_busy           out  1         frame in progress
//  o_tx_done        out  1         1-cycle pulse when the last stop bit completes
// BEHAVIOUR
//  Reset: o_tx=1, o_data_ready=1, o_busy=0, o_tx_done=0, state=IDLE, counters=0.
//   Reset mid-frame drops the frame. o_tx is 1 on the next cycle and no done pulse is generated.
//  Handshake: a word is accepted on the edge where i_data_valid && o_data_ready, independent of i_tick.
//   On that edge:
//    - latch i_data and all i_cfg_*;
//    - o_tx<=0, o_busy<=1, o_data_ready<=0.
//   i_data/i_cfg_* are ignored while busy. Config changes take effect only at the next accept.
//  nbits: cfg 0 or >NB_DATA is treated as NB_DATA.
//  Parity is XOR of the nbits sent data bits only, inverted for odd parity. Unused upper bits are ignored.
//  FSM: IDLE -> START -> DATA -> [PARITY if en] -> STOP -> IDLE.
//   - A bit period ends on the i_tick where tick_cnt==OVERSAMPLE-1. On that edge, tick_cnt<=0 and the next bit value is driven on o_tx.
//   - tick_cnt clears on accept. An i_tick coinciding with the accept edge is not counted.
//   - DATA: bit_cnt runs 0..nbits-1 and shifts out one bit per period.
//   - STOP: o_tx=1 for 1 or 2 bit periods.
//  Frame length: OVERSAMPLE*(1+nbits+parity_en+1+stop2) ticks.
//  End of frame: on the final stop-bit tick edge:
//   - o_tx_done<=1 for exactly 1 cycle;
//   - o_busy<=0, o_data_ready<=1;
//   - o_tx stays 1.
//  Back-to-back: a word may be accepted the cycle after o_data_ready rises. Its start bit follows with no extra idle tick.
//  Without i_tick the FSM holds state and o_tx holds value indefinitely.
// TESTING
//  1 Reset for 2 cycles, then idle -> o_tx=1, o_data_ready=1, o_busy=0, o_tx_done=0. Valid with tick low still accepts.
//  2 8N1, i_tick every cycle, send 0x55 -> o_tx = 0,1,0,1,0,1,0,1,0,1, each held 16 cycles. o_tx_done pulses once, 160 ticks after accept.
//  3 nbits=7, even parity, stop2, 0x7F -> o_tx = 0, 1x7, P=1, 1, 1 (11 bits, 176 ticks). Bit 7 of i_data is never sent.
//  4 nbits=8, odd parity, 0x00 -> parity bit 1. Same word with even parity -> parity bit 0.
//  5 i_tick every 4th cycle, valid held high, cfg toggled mid-frame -> two back-to-back frames with no idle gap. First frame is unaffected by the cfg change.
//  6 Reset asserted during DATA bit 3 -> o_tx=1 next cycle, no o_tx_done, o_data_ready=1. A new frame then sends correctly.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// UART transmitter with run-time frame format: start, 1..NB_DATA data bits LSB first,
// optional even/odd parity, 1 or 2 stop bits; word and format are captured on accept.
module uart_tx_cfg #(
    parameter int NB_DATA    = 8,
    parameter int OVERSAMPLE = 16,
    parameter int NB_NBITS   = 4
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_tick,
    input  logic [NB_DATA-1:0]  i_data,
    input  logic                i_data_valid,
    output logic                o_data_ready,
    input  logic [NB_NBITS-1:0] i_cfg_nbits,
    input  logic                i_cfg_parity_en,
    input  logic                i_cfg_parity_odd,
    input  logic                i_cfg_stop2,
    output logic                o_tx,
    output logic                o_busy,
    output logic                o_tx_done
);
    localparam int                  TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]       TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [NB_NBITS-1:0] NBITS_MAX = NB_NBITS'(NB_DATA);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              state, state_n;
    logic [TW-1:0]       tick_cnt, tick_cnt_n;
    logic [NB_NBITS-1:0] bit_cnt, bit_cnt_n;
    logic [NB_NBITS-1:0] nbits_q, nbits_n, nbits_eff;
    logic [NB_DATA-1:0]  shreg, shreg_n, shifted;
    logic                par_q, par_n, par_en_q, par_en_n, stop2_q, stop2_n;
    logic                tx_n, busy_n, ready_n, done_n;
    logic                par_calc;
    logic                accept, bit_end;

    assign accept  = i_data_valid && o_data_ready;
    assign bit_end = i_tick && (tick_cnt == TICK_LAST);
    assign shifted = shreg >> 1;

    // Parity is fixed at accept time over the bits that will actually be sent.
    always_comb begin
        nbits_eff = i_cfg_nbits;
        if (i_cfg_nbits == '0 || i_cfg_nbits > NBITS_MAX) nbits_eff = NBITS_MAX;
        par_calc = i_cfg_parity_odd;
        for (int i = 0; i < NB_DATA; i++) begin
            if (i < int'(nbits_eff)) par_calc = par_calc ^ i_data[i];
        end
    end

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        nbits_n    = nbits_q;
        shreg_n    = shreg;
        par_n      = par_q;
        par_en_n   = par_en_q;
        stop2_n    = stop2_q;
        tx_n       = o_tx;
        busy_n     = o_busy;
        ready_n    = o_data_ready;
        done_n     = 1'b0;

        if (state != IDLE && i_tick) tick_cnt_n = bit_end ? '0 : tick_cnt + 1'b1;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n    = START;
                    tick_cnt_n = '0;
                    bit_cnt_n  = '0;
                    nbits_n    = nbits_eff;
                    shreg_n    = i_data;
                    par_n      = par_calc;
                    par_en_n   = i_cfg_parity_en;
                    stop2_n    = i_cfg_stop2;
                    tx_n       = 1'b0;
                    busy_n     = 1'b1;
                    ready_n    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    tx_n      = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == nbits_q - 1'b1) begin
                        bit_cnt_n = '0;
                        if (par_en_q) begin
                            state_n = PARITY;
                            tx_n    = par_q;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        shreg_n   = shifted;
                        tx_n      = shifted[0];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n   = STOP;
                    bit_cnt_n = '0;
                    tx_n      = 1'b1;
                end
            end
            STOP: begin
                // bit_cnt doubles as the stop-bit counter
                if (bit_end) begin
                    if (stop2_q && bit_cnt == '0) begin
                        bit_cnt_n = NB_NBITS'(1);
                    end else begin
                        state_n   = IDLE;
                        bit_cnt_n = '0;
                        done_n    = 1'b1;
                        busy_n    = 1'b0;
                        ready_n   = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            nbits_q      <= '0;
            shreg        <= '0;
            par_q        <= 1'b0;
            par_en_q     <= 1'b0;
            stop2_q      <= 1'b0;
            o_tx         <= 1'b1;
            o_busy       <= 1'b0;
            o_data_ready <= 1'b1;
            o_tx_done    <= 1'b0;
        end else begin
            state        <= state_n;
            tick_cnt     <= tick_cnt_n;
            bit_cnt      <= bit_cnt_n;
            nbits_q      <= nbits_n;
            shreg        <= shreg_n;
            par_q        <= par_n;
            par_en_q     <= par_en_n;
            stop2_q      <= stop2_n;
            o_tx         <= tx_n;
            o_busy       <= busy_n;
            o_data_ready <= ready_n;
            o_tx_done    <= done_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: per-cycle line check against a bit-sequence model.
module tb_uart_tx_cfg;
    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst, tick, valid, ready, par_en, par_odd, stop2, tx, busy, done;
    logic [7:0] data;
    logic [3:0] nbits;

    int   total = 0;
    int   bad = 0;
    int   tick_div = 1;
    int   tick_phase = 0;
    bit   tick_en = 1'b1;
    bit   last_tick, last_acc;
    int   tick_seen;
    logic exp_bits [0:15];

    logic [7:0] nxt_data;
    logic [3:0] nxt_nbits;
    logic       nxt_pe, nxt_po, nxt_s2;

    always #5 clk = ~clk;

    uart_tx_cfg #(.NB_DATA(8), .OVERSAMPLE(OS), .NB_NBITS(4)) dut (
        .i_clock(clk), .i_reset(rst), .i_tick(tick),
        .i_data(data), .i_data_valid(valid), .o_data_ready(ready),
        .i_cfg_nbits(nbits), .i_cfg_parity_en(par_en), .i_cfg_parity_odd(par_odd),
        .i_cfg_stop2(stop2), .o_tx(tx), .o_busy(busy), .o_tx_done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: remember what the edge saw, then sample after it and set next tick.
    task automatic cycle();
        last_tick = tick;
        last_acc  = valid && ready && !rst;
        @(posedge clk);
        #1;
        tick_phase = (tick_phase + 1) % tick_div;
        tick = tick_en && (tick_phase == 0);
    endtask

    task automatic set_tick(input bit en, input int div);
        tick_en = en; tick_div = div; tick_phase = 0; tick = en;
    endtask

    task automatic set_inputs(input logic [7:0] d, input logic [3:0] nb,
                              input logic pe, input logic po, input logic s2);
        data = d; nbits = nb; par_en = pe; par_odd = po; stop2 = s2; valid = 1'b1;
    endtask

    task automatic build_model(input logic [7:0] d, input logic [3:0] nb,
                               input logic pe, input logic po, input logic s2);
        int   n;
        int   len;
        logic p;
        n = (nb == 0 || nb > 8) ? 8 : int'(nb);
        p = po;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_bits[1 + i] = d[i];
            p = p ^ d[i];
        end
        len = 1 + n;
        if (pe) begin exp_bits[len] = p; len++; end
        exp_bits[len] = 1'b1; len++;
        if (s2) begin exp_bits[len] = 1'b1; len++; end
        for (int i = len; i < 16; i++) exp_bits[i] = 1'b1;
    endtask

    task automatic wait_accept(input string tag);
        int guard = 0;
        last_acc = 1'b0;
        while (!last_acc && guard < 50) begin
            cycle();
            guard++;
        end
        check({tag, "_accept"}, last_acc, 1);
        check({tag, "_start_tx"}, tx, 0);
        check({tag, "_start_busy"}, busy, 1);
        check({tag, "_start_rdy"}, ready, 0);
    endtask

    task automatic run_frame(input string tag, input int frame_ticks, input bit mid_change);
        int guard = 0;
        tick_seen = 0;
        while (tick_seen < frame_ticks && guard < frame_ticks * 8 + 100) begin
            cycle();
            guard++;
            if (last_tick) tick_seen++;
            if (mid_change && tick_seen == 3 * OS) begin
                data = nxt_data; nbits = nxt_nbits; par_en = nxt_pe; par_odd = nxt_po; stop2 = nxt_s2;
            end
            if (tick_seen < frame_ticks) begin
                check({tag, "_tx"}, tx, exp_bits[tick_seen / OS]);
                check({tag, "_nodone"}, done, 0);
            end
        end
        check({tag, "_len"}, tick_seen, frame_ticks);
        check({tag, "_done"}, done, 1);
        check({tag, "_end_busy"}, busy, 0);
        check({tag, "_end_rdy"}, ready, 1);
        check({tag, "_end_tx"}, tx, 1);
    endtask

    initial begin
        int guard;
        rst = 1'b1; valid = 1'b0; data = 8'h00; nbits = 4'd8;
        par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
        set_tick(1'b1, 1);

        // Reset and idle state
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        check("idle_tx", tx, 1);
        check("idle_rdy", ready, 1);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        // Accept with tick low; line holds while no ticks arrive
        set_tick(1'b0, 1);
        set_inputs(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0);
        build_model(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0);
        wait_accept("t1");
        valid = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        check("t1_hold_tx", tx, 0);
        check("t1_hold_busy", busy, 1);
        set_tick(1'b1, 1);
        run_frame("t1", 160, 1'b0);

        // 8N1 0x55, tick every cycle
        cycle();
        check("t1_done_pulse", done, 0);
        set_inputs(8'h55, 4'd8, 1'b0, 1'b0, 1'b0);
        build_model(8'h55, 4'd8, 1'b0, 1'b0, 1'b0);
        wait_accept("t2");
        valid = 1'b0;
        run_frame("t2", 160, 1'b0);
        cycle();
        check("t2_done_pulse", done, 0);
        check("t2_idle_tx", tx, 1);

        // 7 data bits, even parity, two stops
        set_inputs(8'h7F, 4'd7, 1'b1, 1'b0, 1'b1);
        build_model(8'h7F, 4'd7, 1'b1, 1'b0, 1'b1);
        wait_accept("t3");
        valid = 1'b0;
        run_frame("t3", 176, 1'b0);
        cycle();

        // Odd then even parity of 0x00
        set_inputs(8'h00, 4'd8, 1'b1, 1'b1, 1'b0);
        build_model(8'h00, 4'd8, 1'b1, 1'b1, 1'b0);
        wait_accept("t4o");
        valid = 1'b0;
        run_frame("t4o", 176, 1'b0);
        cycle();
        set_inputs(8'h00, 4'd8, 1'b1, 1'b0, 1'b0);
        build_model(8'h00, 4'd8, 1'b1, 1'b0, 1'b0);
        wait_accept("t4e");
        valid = 1'b0;
        run_frame("t4e", 176, 1'b0);
        cycle();

        // nbits=0 means full width
        set_inputs(8'h81, 4'd0, 1'b0, 1'b0, 1'b0);
        build_model(8'h81, 4'd0, 1'b0, 1'b0, 1'b0);
        wait_accept("t7");
        valid = 1'b0;
        run_frame("t7", 160, 1'b0);
        cycle();

        // Back-to-back with slow tick and a mid-frame config change
        set_tick(1'b1, 4);
        nxt_data = 8'h3C; nxt_nbits = 4'd5; nxt_pe = 1'b1; nxt_po = 1'b1; nxt_s2 = 1'b1;
        set_inputs(8'hC3, 4'd8, 1'b0, 1'b0, 1'b0);
        build_model(8'hC3, 4'd8, 1'b0, 1'b0, 1'b0);
        wait_accept("t5a");
        run_frame("t5a", 160, 1'b1);
        build_model(nxt_data, nxt_nbits, nxt_pe, nxt_po, nxt_s2);
        cycle();
        check("t5_b2b_accept", last_acc, 1);
        check("t5_b2b_tx", tx, 0);
        check("t5_b2b_busy", busy, 1);
        valid = 1'b0;
        run_frame("t5b", 144, 1'b0);
        cycle();
        check("t5_done_pulse", done, 0);

        // Reset during data bit 3 drops the frame
        set_tick(1'b1, 1);
        set_inputs(8'hF7, 4'd8, 1'b0, 1'b0, 1'b0);
        build_model(8'hF7, 4'd8, 1'b0, 1'b0, 1'b0);
        wait_accept("t6");
        valid = 1'b0;
        tick_seen = 0;
        guard = 0;
        while (tick_seen < 4 * OS + 5 && guard < 500) begin
            cycle();
            guard++;
            if (last_tick) tick_seen++;
        end
        check("t6_bit3_tx", tx, 0);
        rst = 1'b1;
        cycle();
        check("t6_rst_tx", tx, 1);
        check("t6_rst_rdy", ready, 1);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            check("t6_post_done", done, 0);
            check("t6_post_tx", tx, 1);
        end
        set_inputs(8'h96, 4'd8, 1'b1, 1'b0, 1'b0);
        build_model(8'h96, 4'd8, 1'b1, 1'b0, 1'b0);
        wait_accept("t6n");
        valid = 1'b0;
        run_frame("t6n", 176, 1'b0);
        cycle();
        check("t6n_done_pulse", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
